// File: rtl/vram_slot_port.sv
// -----------------------------------------------------------------------------
// vram_slot_port
//
// Shared single-port video RAM port that sits behind the access manager. The
// RAM is granted only in the access slots marked by mainCE (main logic) and
// pacmanCE (pacman sprite engine). Each client owns a 1-deep request holding
// register. Read data comes back through a tagged latency pipe so that each
// client receives only its own data.
//
// Parameters
//   ADDR_W  RAM address width
//   DATA_W  RAM data width
//   RD_LAT  RAM read latency in cycles (1..3); rvalid appears RD_LAT+1 cycles
//           after the slot cycle in which the read was issued
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   mainCE, pacmanCE  access slot enables
//   main_stb/we/addr/wdata -> main_ack        main request and capture pulse
//   main_rvalid, main_rdata                   main read return
//   pac_stb/addr -> pac_ack                   pacman read request and capture pulse
//   pac_rvalid, pac_rdata                     pacman read return
//   ram_addr/wdata/we (out), ram_rdata (in)   RAM side, outputs registered
//   err_flags         sticky {slot conflict, pac overrun, main overrun}
// -----------------------------------------------------------------------------
module vram_slot_port #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mainCE,
   input  logic              pacmanCE,
   input  logic              main_stb,
   input  logic              main_we,
   input  logic [ADDR_W-1:0] main_addr,
   input  logic [DATA_W-1:0] main_wdata,
   output logic              main_ack,
   output logic              main_rvalid,
   output logic [DATA_W-1:0] main_rdata,
   input  logic              pac_stb,
   input  logic [ADDR_W-1:0] pac_addr,
   output logic              pac_ack,
   output logic              pac_rvalid,
   output logic [DATA_W-1:0] pac_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [2:0]        err_flags
);

   // Request holding registers
   logic              r_main_pend;
   logic              r_main_we;
   logic [ADDR_W-1:0] r_main_addr;
   logic [DATA_W-1:0] r_main_wdata;
   logic              r_pac_pend;
   logic [ADDR_W-1:0] r_pac_addr;

   // Registered outputs
   logic              r_main_ack;
   logic              r_pac_ack;
   logic              r_main_rvalid;
   logic              r_pac_rvalid;
   logic [DATA_W-1:0] r_main_rdata;
   logic [DATA_W-1:0] r_pac_rdata;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic              r_ram_we;
   logic [2:0]        r_err;

   // Return pipe: one valid bit and one client tag (1 = pacman) per stage
   logic [RD_LAT-1:0] r_pipe_vld;
   logic [RD_LAT-1:0] r_pipe_pac;

   logic w_main_cap;
   logic w_pac_cap;
   logic w_main_issue;
   logic w_pac_issue;
   logic w_rd_issue;
   logic w_exit_vld;
   logic w_exit_pac;

   // Capture only looks at the pending bit before this edge, so a strobe that
   // arrives while the old request is issuing is still treated as an overrun.
   assign w_main_cap   = main_stb & ~r_main_pend;
   assign w_pac_cap    = pac_stb  & ~r_pac_pend;

   // Pacman has priority when both slots coincide; main can still take a
   // shared slot when pacman has nothing pending.
   assign w_pac_issue  = pacmanCE & r_pac_pend;
   assign w_main_issue = mainCE & r_main_pend & ~w_pac_issue;

   // Writes never enter the return pipe.
   assign w_rd_issue   = w_pac_issue | (w_main_issue & ~r_main_we);

   assign w_exit_vld   = r_pipe_vld[RD_LAT-1];
   assign w_exit_pac   = r_pipe_pac[RD_LAT-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_main_pend   <= 1'b0;
         r_main_we     <= 1'b0;
         r_main_addr   <= '0;
         r_main_wdata  <= '0;
         r_pac_pend    <= 1'b0;
         r_pac_addr    <= '0;
         r_main_ack    <= 1'b0;
         r_pac_ack     <= 1'b0;
         r_main_rvalid <= 1'b0;
         r_pac_rvalid  <= 1'b0;
         r_main_rdata  <= '0;
         r_pac_rdata   <= '0;
         r_ram_addr    <= '0;
         r_ram_wdata   <= '0;
         r_ram_we      <= 1'b0;
         r_err         <= 3'b000;
         r_pipe_vld    <= '0;
         r_pipe_pac    <= '0;
      end else begin
         // Capture
         r_main_ack <= w_main_cap;
         r_pac_ack  <= w_pac_cap;

         if (w_main_cap) begin
            r_main_pend  <= 1'b1;
            r_main_we    <= main_we;
            r_main_addr  <= main_addr;
            r_main_wdata <= main_wdata;
         end else if (w_main_issue) begin
            r_main_pend  <= 1'b0;
         end

         if (w_pac_cap) begin
            r_pac_pend <= 1'b1;
            r_pac_addr <= pac_addr;
         end else if (w_pac_issue) begin
            r_pac_pend <= 1'b0;
         end

         // Sticky error flags
         if (main_stb & r_main_pend) r_err[0] <= 1'b1;
         if (pac_stb & r_pac_pend)   r_err[1] <= 1'b1;
         if (mainCE & pacmanCE)      r_err[2] <= 1'b1;

         // Issue to RAM; address and write data hold when idle
         r_ram_we <= w_main_issue & r_main_we;
         if (w_pac_issue) begin
            r_ram_addr  <= r_pac_addr;
         end else if (w_main_issue) begin
            r_ram_addr  <= r_main_addr;
            r_ram_wdata <= r_main_wdata;
         end

         // Return pipe
         r_pipe_vld[0] <= w_rd_issue;
         r_pipe_pac[0] <= w_pac_issue;
         for (int i = 1; i < RD_LAT; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_pac[i] <= r_pipe_pac[i-1];
         end

         // Return to the tagged client
         r_main_rvalid <= w_exit_vld & ~w_exit_pac;
         r_pac_rvalid  <= w_exit_vld & w_exit_pac;
         if (w_exit_vld & ~w_exit_pac) r_main_rdata <= ram_rdata;
         if (w_exit_vld & w_exit_pac)  r_pac_rdata  <= ram_rdata;
      end
   end

   assign main_ack    = r_main_ack;
   assign main_rvalid = r_main_rvalid;
   assign main_rdata  = r_main_rdata;
   assign pac_ack     = r_pac_ack;
   assign pac_rvalid  = r_pac_rvalid;
   assign pac_rdata   = r_pac_rdata;
   assign ram_addr    = r_ram_addr;
   assign ram_wdata   = r_ram_wdata;
   assign ram_we      = r_ram_we;
   assign err_flags   = r_err;

endmodule

// File: tb/tb_vram_slot_port.sv
// -----------------------------------------------------------------------------
// tb_vram_slot_port
//
// Bench for vram_slot_port with RD_LAT=2. The RAM is a fixed lookup
// ram_f(addr) behind a register stage so that data arrives in the cycle the
// port captures it. A transaction-level model (pending flags, hold values and
// a queue of timestamped read returns) predicts every output after each clock
// edge; directed sequences pin literal values, then random traffic runs.
// -----------------------------------------------------------------------------
module tb_vram_slot_port;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              mainCE = 1'b0;
   logic              pacmanCE = 1'b0;
   logic              main_stb = 1'b0;
   logic              main_we = 1'b0;
   logic [ADDR_W-1:0] main_addr = '0;
   logic [DATA_W-1:0] main_wdata = '0;
   logic              main_ack;
   logic              main_rvalid;
   logic [DATA_W-1:0] main_rdata;
   logic              pac_stb = 1'b0;
   logic [ADDR_W-1:0] pac_addr = '0;
   logic              pac_ack;
   logic              pac_rvalid;
   logic [DATA_W-1:0] pac_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;
   logic [2:0]        err_flags;

   int n_chk  = 0;
   int n_fail = 0;

   vram_slot_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset), .mainCE(mainCE), .pacmanCE(pacmanCE),
      .main_stb(main_stb), .main_we(main_we), .main_addr(main_addr),
      .main_wdata(main_wdata), .main_ack(main_ack), .main_rvalid(main_rvalid),
      .main_rdata(main_rdata), .pac_stb(pac_stb), .pac_addr(pac_addr),
      .pac_ack(pac_ack), .pac_rvalid(pac_rvalid), .pac_rdata(pac_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_rdata(ram_rdata), .err_flags(err_flags)
   );

   always #5 clk = ~clk;

   // RAM contents as a fixed function of the address
   function automatic logic [7:0] ram_f(input logic [9:0] a);
      return a[7:0] ^ {a[9:8], 6'h1C};
   endfunction

   logic [ADDR_W-1:0] ram_addr_d = '0;
   always @(posedge clk) ram_addr_d <= ram_addr;
   assign ram_rdata = ram_f(ram_addr_d);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int         due;
      bit         pac;
      logic [7:0] data;
   } ev_t;

   ev_t        evq[$];
   int         cyc = 0;
   bit         m_main_pend = 0, m_pac_pend = 0, m_main_we = 0;
   logic [9:0] m_main_addr = '0, m_pac_addr = '0;
   logic [7:0] m_main_wdata = '0;
   logic       e_main_ack = 0, e_pac_ack = 0, e_main_rvalid = 0, e_pac_rvalid = 0, e_ram_we = 0;
   logic [7:0] e_main_rdata = '0, e_pac_rdata = '0, e_ram_wdata = '0;
   logic [9:0] e_ram_addr = '0;
   logic [2:0] e_err = '0;

   always @(posedge clk) begin : model
      bit mp, pp, piss, miss;
      cyc++;
      if (!reset) begin
         m_main_pend = 0; m_pac_pend = 0; m_main_we = 0;
         m_main_addr = '0; m_pac_addr = '0; m_main_wdata = '0;
         e_main_ack = 0; e_pac_ack = 0; e_main_rvalid = 0; e_pac_rvalid = 0;
         e_ram_we = 0; e_main_rdata = '0; e_pac_rdata = '0; e_ram_wdata = '0;
         e_ram_addr = '0; e_err = '0;
         evq.delete();
      end else begin
         mp   = m_main_pend;
         pp   = m_pac_pend;
         piss = pacmanCE && pp;
         miss = mainCE && mp && !piss;
         if (main_stb && mp)     e_err[0] = 1'b1;
         if (pac_stb && pp)      e_err[1] = 1'b1;
         if (mainCE && pacmanCE) e_err[2] = 1'b1;
         e_ram_we = 1'b0;
         if (piss) begin
            e_ram_addr = m_pac_addr;
            evq.push_back('{due: cyc + RD_LAT, pac: 1'b1, data: ram_f(m_pac_addr)});
            m_pac_pend = 0;
         end
         if (miss) begin
            e_ram_addr  = m_main_addr;
            e_ram_wdata = m_main_wdata;
            e_ram_we    = m_main_we;
            if (!m_main_we)
               evq.push_back('{due: cyc + RD_LAT, pac: 1'b0, data: ram_f(m_main_addr)});
            m_main_pend = 0;
         end
         e_main_ack = main_stb && !mp;
         e_pac_ack  = pac_stb && !pp;
         if (e_main_ack) begin
            m_main_pend = 1; m_main_we = main_we;
            m_main_addr = main_addr; m_main_wdata = main_wdata;
         end
         if (e_pac_ack) begin
            m_pac_pend = 1; m_pac_addr = pac_addr;
         end
         e_main_rvalid = 0;
         e_pac_rvalid  = 0;
         while (evq.size() > 0 && evq[0].due == cyc) begin
            if (evq[0].pac) begin e_pac_rvalid = 1; e_pac_rdata = evq[0].data; end
            else            begin e_main_rvalid = 1; e_main_rdata = evq[0].data; end
            void'(evq.pop_front());
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #2;
      check("main_ack",    32'(main_ack),    32'(e_main_ack));
      check("pac_ack",     32'(pac_ack),     32'(e_pac_ack));
      check("main_rvalid", 32'(main_rvalid), 32'(e_main_rvalid));
      check("pac_rvalid",  32'(pac_rvalid),  32'(e_pac_rvalid));
      check("main_rdata",  32'(main_rdata),  32'(e_main_rdata));
      check("pac_rdata",   32'(pac_rdata),   32'(e_pac_rdata));
      check("ram_addr",    32'(ram_addr),    32'(e_ram_addr));
      check("ram_wdata",   32'(ram_wdata),   32'(e_ram_wdata));
      check("ram_we",      32'(ram_we),      32'(e_ram_we));
      check("err_flags",   32'(err_flags),   32'(e_err));
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      mainCE = 0; pacmanCE = 0; main_stb = 0; pac_stb = 0; main_we = 0;
   endtask

   task automatic randomize_inputs(input int stb_div, input int ce_div);
      main_stb   = ($urandom % stb_div) == 0;
      pac_stb    = ($urandom % stb_div) == 0;
      main_we    = $urandom % 2;
      main_addr  = 10'($urandom);
      main_wdata = 8'($urandom);
      pac_addr   = 10'($urandom);
      mainCE     = ($urandom % ce_div) == 0;
      pacmanCE   = ($urandom % ce_div) == 0;
   endtask

   initial begin
      // Reset held with random inputs
      reset = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         randomize_inputs(2, 2);
         check("rst_ram_we",    32'(ram_we),    32'h0);
         check("rst_err_flags", 32'(err_flags), 32'h0);
         check("rst_main_ack",  32'(main_ack),  32'h0);
      end
      @(negedge clk);
      idle();
      reset = 1;
      repeat (3) @(negedge clk);
      check("post_rst_ram_addr", 32'(ram_addr), 32'h0);
      check("post_rst_pac_ack",  32'(pac_ack),  32'h0);

      // Main write: stb t0, mainCE t3, write visible at t4
      main_stb = 1; main_we = 1; main_addr = 10'h155; main_wdata = 8'hA5;
      @(negedge clk);                                   // t1
      check("wr_ack", 32'(main_ack), 32'h1);
      idle();
      @(negedge clk);                                   // t2
      check("wr_ack_pulse", 32'(main_ack), 32'h0);
      @(negedge clk);                                   // t3
      mainCE = 1;
      @(negedge clk);                                   // t4
      idle();
      check("wr_addr",  32'(ram_addr),  32'h155);
      check("wr_wdata", 32'(ram_wdata), 32'hA5);
      check("wr_we",    32'(ram_we),    32'h1);
      @(negedge clk);                                   // t5
      check("wr_we_once", 32'(ram_we),      32'h0);
      check("wr_no_rv",   32'(main_rvalid), 32'h0);
      repeat (3) @(negedge clk);

      // Pacman read: stb t0, pacmanCE t2, rvalid t5 with 0x3C
      pac_stb = 1; pac_addr = 10'h020;
      @(negedge clk);                                   // t1
      check("pr_ack", 32'(pac_ack), 32'h1);
      pac_stb = 0;
      @(negedge clk);                                   // t2
      pacmanCE = 1;
      @(negedge clk);                                   // t3
      pacmanCE = 0;
      check("pr_addr", 32'(ram_addr), 32'h020);
      check("pr_we",   32'(ram_we),   32'h0);
      @(negedge clk);                                   // t4
      check("pr_early", 32'(pac_rvalid), 32'h0);
      @(negedge clk);                                   // t5
      check("pr_rvalid", 32'(pac_rvalid),  32'h1);
      check("pr_rdata",  32'(pac_rdata),   32'h3C);
      check("pr_main_rv", 32'(main_rvalid), 32'h0);
      @(negedge clk);                                   // t6
      check("pr_hold",  32'(pac_rdata),  32'h3C);
      check("pr_noerr", 32'(err_flags),  32'h0);
      repeat (2) @(negedge clk);

      // Conflict: both pending, both CEs at t5
      main_stb = 1; main_we = 0; main_addr = 10'h0AB;
      pac_stb = 1; pac_addr = 10'h301;
      @(negedge clk);                                   // t1
      check("cf_main_ack", 32'(main_ack), 32'h1);
      check("cf_pac_ack",  32'(pac_ack),  32'h1);
      idle();
      repeat (4) @(negedge clk);                        // t5
      mainCE = 1; pacmanCE = 1;
      @(negedge clk);                                   // t6
      check("cf_pac_addr", 32'(ram_addr),     32'h301);
      check("cf_err2",     32'(err_flags[2]), 32'h1);
      pacmanCE = 0;
      @(negedge clk);                                   // t7
      mainCE = 0;
      check("cf_main_addr", 32'(ram_addr),  32'h0AB);
      check("cf_err",       32'(err_flags), 32'h4);
      @(negedge clk);                                   // t8
      check("cf_pac_rv", 32'(pac_rvalid), 32'h1);
      check("cf_pac_rd", 32'(pac_rdata),  32'hDD);
      @(negedge clk);                                   // t9
      check("cf_main_rv", 32'(main_rvalid), 32'h1);
      check("cf_main_rd", 32'(main_rdata),  32'hB7);
      repeat (2) @(negedge clk);

      // Overrun
      main_stb = 1; main_we = 1; main_addr = 10'h3FF; main_wdata = 8'h5A;
      @(negedge clk);                                   // t1
      check("ov_ack1", 32'(main_ack), 32'h1);
      main_addr = 10'h000; main_wdata = 8'hFF;
      @(negedge clk);                                   // t2
      check("ov_ack2", 32'(main_ack),  32'h0);
      check("ov_err",  32'(err_flags), 32'h5);
      main_stb = 0; mainCE = 1;
      @(negedge clk);                                   // t3
      mainCE = 0;
      check("ov_addr",  32'(ram_addr),  32'h3FF);
      check("ov_wdata", 32'(ram_wdata), 32'h5A);
      check("ov_we",    32'(ram_we),    32'h1);
      repeat (2) @(negedge clk);

      // Reset one cycle after a read issue
      main_stb = 1; main_we = 0; main_addr = 10'h111;
      @(negedge clk);                                   // t1
      main_stb = 0; mainCE = 1;
      @(negedge clk);                                   // t2
      mainCE = 0;
      check("rr_addr", 32'(ram_addr), 32'h111);
      reset = 0;
      #1;
      check("rr_async_addr", 32'(ram_addr),  32'h0);
      check("rr_async_err",  32'(err_flags), 32'h0);
      @(negedge clk);
      reset = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rr_no_rvalid", 32'(main_rvalid), 32'h0);
      end

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         randomize_inputs((i < 1500) ? 3 : 2, (i < 1500) ? 3 : 2);
         reset = ($urandom % 400) != 0;
      end
      @(negedge clk);
      idle();
      reset = 1;
      repeat (8) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
